// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for the multicycle MIPS datapath: sequences fetch,
// decode and execute steps and drives every datapath select and write enable.
module multicycle_ctrl #(
    parameter bit FETCH_PC_INC = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     cur;
    state_t     nxt;
    logic       pcwrite;
    logic       branch;
    logic       funct_ok;
    logic [2:0] funct_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= S_FETCH;
        else
            cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                      nxt = S_MEMADR;
                    OP_RTYPE:                          nxt = S_RTYPEEX;
                    OP_BEQ:                            nxt = S_BEQEX;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  nxt = S_IMMEX;
                    OP_J:                              nxt = S_JEX;
                    default:                           nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nxt = S_MEMWB;
            S_RTYPEEX: nxt = S_RTYPEWB;
            S_IMMEX:   nxt = S_IMMWB;
            default:   nxt = S_FETCH;
        endcase
    end

    // Reset masks every write enable and pulse so an aborted instruction leaves no trace.
    always_comb begin
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immsrc     = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        retire     = 1'b0;
        illegal    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (cur)
            S_FETCH: begin
                irwrite    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                pcwrite    = FETCH_PC_INC;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
                if (nxt == S_FETCH) begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = funct_ok;
                illegal  = ~funct_ok;
                retire   = 1'b1;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                retire     = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ADDI: begin immsrc = 2'b00; alucontrol = 3'b010; end
                    OP_ANDI: begin immsrc = 2'b01; alucontrol = 3'b000; end
                    OP_ORI:  begin immsrc = 2'b01; alucontrol = 3'b001; end
                    OP_LUI:  begin immsrc = 2'b10; alucontrol = 3'b001; end
                    default: begin immsrc = 2'b00; alucontrol = 3'b000; end
                endcase
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: walks each instruction
// class through its state sequence and checks the control outputs per state.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'b000000;
    logic [5:0] funct = 6'b100000;
    logic       zero = 1'b0;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, immsrc, pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       retire, illegal;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.FETCH_PC_INC(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc), .pcsrc(pcsrc), .pcen(pcen),
        .alucontrol(alucontrol), .retire(retire), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (state !== 4'd0 || irwrite !== 1'b0 || pcen !== 1'b0 || retire !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_hold: state=%0d irwrite=%b pcen=%b retire=%b, want 0 0 0 0",
                     state, irwrite, pcen, retire);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || irwrite !== 1'b1 || pcen !== 1'b1 || alusrcb !== 2'b01) begin
            failures++;
            $display("[TB] FAIL fetch_after_reset: state=%0d irwrite=%b pcen=%b alusrcb=%b, want 0 1 1 01",
                     state, irwrite, pcen, alusrcb);
        end
        op = 6'b100011;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd3 || iord !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lw_to_memrd: state=%0d iord=%b, want 3 1", state, iord);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0 || pcen !== 1'b0 || irwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: state=%0d mw=%b rw=%b pcen=%b irw=%b, want 0 0 0 0 0",
                     state, memwrite, regwrite, pcen, irwrite);
        end
        tick();
        checks++;
        if (state !== 4'd0 || regwrite !== 1'b0 || retire !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_across_edge: state=%0d rw=%b retire=%b, want 0 0 0", state, regwrite, retire);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (irwrite !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_irwrite: got %b want 1", irwrite);
        end
        tick();
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("[TB] FAIL release_decode: state=%0d want 1", state);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("[TB] FAIL restart_lw_done: state=%0d want 0", state);
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_states [5];
        int retires = 0;
        exp_states = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp_states[i]) begin
                failures++;
                $display("[TB] FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_states[i]);
            end
            if (retire === 1'b1) retires++;
            if (i == 2) begin
                checks++;
                if (alusrca !== 1'b1 || alusrcb !== 2'b10 || immsrc !== 2'b00 || alucontrol !== 3'b010) begin
                    failures++;
                    $display("[TB] FAIL lw_memadr: srca=%b srcb=%b imm=%b alu=%b, want 1 10 00 010",
                             alusrca, alusrcb, immsrc, alucontrol);
                end
            end
            if (i == 4) begin
                checks++;
                if (regwrite !== 1'b1 || memtoreg !== 1'b1 || regdst !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL lw_memwb: rw=%b m2r=%b rd=%b, want 1 1 0", regwrite, memtoreg, regdst);
                end
            end
            tick();
        end
        checks++;
        if (retires != 1 || state !== 4'd0) begin
            failures++;
            $display("[TB] FAIL lw_retire: retires=%0d end_state=%0d, want 1 0", retires, state);
        end
    endtask

    task automatic test_sw();
        op = 6'b101011;
        tick(); tick(); tick();
        checks++;
        if (state !== 4'd5 || memwrite !== 1'b1 || iord !== 1'b1 || retire !== 1'b1 || regwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sw_memwr: state=%0d mw=%b iord=%b retire=%b rw=%b, want 5 1 1 1 0",
                     state, memwrite, iord, retire, regwrite);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("[TB] FAIL sw_done: state=%0d want 0", state);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] f [6];
        logic [2:0] a [6];
        f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
        a = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        op = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = f[i];
            tick(); tick();
            checks++;
            if (state !== 4'd6 || alucontrol !== a[i] || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
                failures++;
                $display("[TB] FAIL rtype_ex[%b]: state=%0d alu=%b srca=%b srcb=%b, want 6 %b 1 00",
                         f[i], state, alucontrol, alusrca, alusrcb, a[i]);
            end
            tick();
            checks++;
            if (state !== 4'd7 || regwrite !== (i < 5) || illegal !== (i == 5)
                || regdst !== 1'b1 || retire !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rtype_wb[%b]: state=%0d rw=%b ill=%b rd=%b retire=%b, want 7 %b %b 1 1",
                         f[i], state, regwrite, illegal, regdst, retire, (i < 5), (i == 5));
            end
            tick();
        end
    endtask

    task automatic test_beq();
        logic [1:0] zv;
        zv = 2'b01;
        op = 6'b000100;
        for (int i = 0; i < 2; i++) begin
            zero = zv[i];
            tick(); tick();
            checks++;
            if (state !== 4'd8 || pcen !== zv[i] || pcsrc !== 2'b01 || alucontrol !== 3'b110 || retire !== 1'b1) begin
                failures++;
                $display("[TB] FAIL beq_ex[zero=%b]: state=%0d pcen=%b pcsrc=%b alu=%b retire=%b, want 8 %b 01 110 1",
                         zv[i], state, pcen, pcsrc, alucontrol, retire, zv[i]);
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                failures++;
                $display("[TB] FAIL beq_done[zero=%b]: state=%0d want 0", zv[i], state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_imm();
        logic [5:0] o [4];
        logic [1:0] s [4];
        logic [2:0] a [4];
        o = '{6'b001100, 6'b001111, 6'b001000, 6'b001101};
        s = '{2'b01, 2'b10, 2'b00, 2'b01};
        a = '{3'b000, 3'b001, 3'b010, 3'b001};
        for (int i = 0; i < 4; i++) begin
            op = o[i];
            tick(); tick();
            checks++;
            if (state !== 4'd9 || immsrc !== s[i] || alucontrol !== a[i] || alusrcb !== 2'b10) begin
                failures++;
                $display("[TB] FAIL imm_ex[%b]: state=%0d immsrc=%b alu=%b srcb=%b, want 9 %b %b 10",
                         o[i], state, immsrc, alucontrol, alusrcb, s[i], a[i]);
            end
            tick();
            checks++;
            if (state !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0 || retire !== 1'b1) begin
                failures++;
                $display("[TB] FAIL imm_wb[%b]: state=%0d rw=%b rd=%b m2r=%b retire=%b, want 10 1 0 0 1",
                         o[i], state, regwrite, regdst, memtoreg, retire);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        op = 6'b111111;
        tick();
        checks++;
        if (state !== 4'd1 || illegal !== 1'b1 || retire !== 1'b1 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_op: state=%0d ill=%b retire=%b mw=%b rw=%b, want 1 1 1 0 0",
                     state, illegal, retire, memwrite, regwrite);
        end
        tick();
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL illegal_return: state=%0d ill=%b, want 0 0", state, illegal);
        end
        op = 6'b000010;
        tick(); tick();
        checks++;
        if (state !== 4'd11 || pcsrc !== 2'b10 || pcen !== 1'b1 || retire !== 1'b1) begin
            failures++;
            $display("[TB] FAIL j_ex: state=%0d pcsrc=%b pcen=%b retire=%b, want 11 10 1 1",
                     state, pcsrc, pcen, retire);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            failures++;
            $display("[TB] FAIL j_done: state=%0d want 0", state);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_imm();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
